shift_add_multiplier: RTL and testbench

Parametrised sequential shift-add multiplier that generalises the lab 8-bit multiplier datapath to WIDTH bits. It adds a start/done handshake and an optional unsigned mode. It holds the multiplicand on the switch input S and the multiplier/product-low half in register B. The product is formed in {X, A, B} over 2*WIDTH clock cycles. It sits below the board top level, which drives hex displays and LEDs from Aval/Bval/X.

---
 rtl/shift_add_multiplier.sv | 115 +++++++++++
 tb/tb_shift_add_multiplier.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// The product is built in {X, A, B} over 2*WIDTH cycles: one ADD and one SHIFT per multiplier bit.
// Optional feature macro: MULT_UNSIGNED_MODE_EN adds a Mode port (1 = signed, 0 = unsigned).
// Without the macro the block is always signed two's complement.
module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             ClearA_LoadB,
    input  logic             Run,
    input  logic [WIDTH-1:0] S,
`ifdef MULT_UNSIGNED_MODE_EN
    input  logic             Mode,
`endif
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             X,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADD   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state, state_d;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic             x_reg;
    logic             signed_mode;
    logic             last;
    logic [WIDTH:0]   a_ext, s_ext, sum;

`ifdef MULT_UNSIGNED_MODE_EN
    assign signed_mode = Mode;
`else
    assign signed_mode = 1'b1;
`endif

    assign last = (cnt == CW'(WIDTH - 1));

    // Partial-product adder: WIDTH+1 bits wide so X captures sign (signed) or carry (unsigned).
    // The final signed iteration subtracts because the multiplier MSB carries negative weight.
    always_comb begin
        a_ext = signed_mode ? {a_reg[WIDTH-1], a_reg} : {1'b0, a_reg};
        s_ext = signed_mode ? {S[WIDTH-1], S}         : {1'b0, S};
        sum   = (signed_mode && last) ? (a_ext - s_ext) : (a_ext + s_ext);
    end

    // State register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= ST_IDLE;
        else        state <= state_d;
    end

    // Next-state logic; ClearA_LoadB has priority over Run in IDLE
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:  if (!ClearA_LoadB && Run) state_d = ST_ADD;
            ST_ADD:   state_d = ST_SHIFT;
            ST_SHIFT: state_d = last ? ST_DONE : ST_ADD;
            ST_DONE:  if (!Run) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath: A/B/X registers and iteration counter
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            a_reg <= '0;
            b_reg <= '0;
            x_reg <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ClearA_LoadB) begin
                        a_reg <= '0;
                        x_reg <= 1'b0;
                        b_reg <= S;
                    end else if (Run) begin
                        // B is kept so back-to-back multiplies chain on the previous low half
                        a_reg <= '0;
                        x_reg <= 1'b0;
                        cnt   <= '0;
                    end
                end
                ST_ADD: begin
                    if (b_reg[0]) {x_reg, a_reg} <= sum;
                end
                ST_SHIFT: begin
                    a_reg <= {x_reg, a_reg[WIDTH-1:1]};
                    b_reg <= {a_reg[0], b_reg[WIDTH-1:1]};
                    x_reg <= signed_mode ? x_reg : 1'b0;
                    cnt   <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign Aval = a_reg;
    assign Bval = b_reg;
    assign X    = x_reg;
    assign Busy = (state == ST_ADD) || (state == ST_SHIFT);
    assign Done = (state == ST_DONE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed checks of the WIDTH=8 shift-add multiplier.
// Unsigned-mode vectors run only when MULT_UNSIGNED_MODE_EN is defined.
module tb_shift_add_multiplier;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       ClearA_LoadB = 1'b0;
    logic       Run = 1'b0;
    logic [7:0] S = 8'h00;
    logic [7:0] Aval, Bval;
    logic       X, Busy, Done;
`ifdef MULT_UNSIGNED_MODE_EN
    logic       Mode = 1'b1;
`endif

    int n_cmp = 0;
    int n_err = 0;

    shift_add_multiplier #(.WIDTH(8)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .ClearA_LoadB (ClearA_LoadB),
        .Run          (Run),
        .S            (S),
`ifdef MULT_UNSIGNED_MODE_EN
        .Mode         (Mode),
`endif
        .Aval         (Aval),
        .Bval         (Bval),
        .X            (X),
        .Busy         (Busy),
        .Done         (Done)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_b(input logic [7:0] v);
        ClearA_LoadB = 1'b1;
        S = v;
        tick();
        ClearA_LoadB = 1'b0;
    endtask

    // Edge 0: Run sampled in IDLE; Busy must be up right after it
    task automatic start(input logic [7:0] s, input string tag);
        S = s;
        Run = 1'b1;
        tick();
        chk({tag, " busy_after_start"}, int'(Busy), 1);
    endtask

    // Waits (bounded) for Done; it must appear 16 edges after edge 0
    task automatic wait_done(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                             input logic ex);
        int cyc = 0;
        while (!Done && cyc < 60) begin
            tick();
            cyc++;
        end
        chk({tag, " latency"}, cyc, 16);
        chk({tag, " A"}, int'(Aval), int'(ea));
        chk({tag, " B"}, int'(Bval), int'(eb));
        chk({tag, " X"}, int'(X), int'(ex));
        chk({tag, " busy_at_done"}, int'(Busy), 0);
    endtask

    task automatic release_run(input string tag);
        Run = 1'b0;
        tick();
        chk({tag, " done_falls"}, int'(Done), 0);
    endtask

    task automatic mult(input logic [7:0] s, input logic [7:0] ea, input logic [7:0] eb,
                        input logic ex, input string tag);
        start(s, tag);
        wait_done(tag, ea, eb, ex);
        release_run(tag);
    endtask

    initial begin
        // Reset state
        #2 Reset = 1'b0;
        #2;
        chk("rst A", int'(Aval), 0);
        chk("rst B", int'(Bval), 0);
        chk("rst X", int'(X), 0);
        chk("rst busy", int'(Busy), 0);
        chk("rst done", int'(Done), 0);
        tick();
        #2 Reset = 1'b1;
        tick();

        // Signed positive: 7 * 59 = 413 = 0x019D
        load_b(8'h07);
        chk("load B", int'(Bval), 8'h07);
        mult(8'h3B, 8'h01, 8'h9D, 1'b0, "pos");

        // Consecutive: B = 0x9D (-99) * 2 = -198 = 0xFF3A
        mult(8'h02, 8'hFF, 8'h3A, 1'b1, "chain");

        // Run held for 40 cycles: exactly one multiply, Done held until release
        load_b(8'h07);
        S = 8'h3B;
        Run = 1'b1;
        repeat (40) tick();
        chk("hold done", int'(Done), 1);
        chk("hold A", int'(Aval), 8'h01);
        chk("hold B", int'(Bval), 8'h9D);
        release_run("hold");
        chk("hold busy_after_release", int'(Busy), 0);

        // Signed mixed: 59 * -7 = -413 = 0xFE63 ; -59 * -7 = 413
        load_b(8'h3B);
        mult(8'hF9, 8'hFE, 8'h63, 1'b1, "mixed");
        load_b(8'hC5);
        mult(8'hF9, 8'h01, 8'h9D, 1'b0, "negneg");

        // Priority: ClearA_LoadB wins over Run in IDLE
        ClearA_LoadB = 1'b1;
        Run = 1'b1;
        S = 8'h55;
        tick();
        chk("prio B", int'(Bval), 8'h55);
        chk("prio A", int'(Aval), 0);
        chk("prio busy", int'(Busy), 0);
        ClearA_LoadB = 1'b0;
        Run = 1'b0;
        tick();
        chk("prio busy_idle", int'(Busy), 0);

        // ClearA_LoadB pulsed mid-multiply must be ignored
        load_b(8'h07);
        start(8'h3B, "midclr");
        repeat (3) tick();
        ClearA_LoadB = 1'b1;
        tick();
        ClearA_LoadB = 1'b0;
        begin
            int cyc = 4;
            while (!Done && cyc < 60) begin
                tick();
                cyc++;
            end
            chk("midclr latency", cyc, 16);
        end
        chk("midclr A", int'(Aval), 8'h01);
        chk("midclr B", int'(Bval), 8'h9D);
        release_run("midclr");

        // Reset in SHIFT_3 (7 edges after edge 0), then a fresh multiply
        load_b(8'h07);
        start(8'h3B, "rstmid");
        repeat (7) tick();
        chk("rstmid busy_before", int'(Busy), 1);
        #2 Reset = 1'b0;
        #1;
        chk("rstmid A", int'(Aval), 0);
        chk("rstmid B", int'(Bval), 0);
        chk("rstmid X", int'(X), 0);
        chk("rstmid busy", int'(Busy), 0);
        chk("rstmid done", int'(Done), 0);
        Run = 1'b0;
        tick();
        #2 Reset = 1'b1;
        tick();
        load_b(8'hC5);
        mult(8'hF9, 8'h01, 8'h9D, 1'b0, "after_rst");

`ifdef MULT_UNSIGNED_MODE_EN
        // Unsigned: 255 * 255 = 0xFE01 ; signed: -1 * -1 = 1
        Mode = 1'b0;
        load_b(8'hFF);
        mult(8'hFF, 8'hFE, 8'h01, 1'b0, "unsigned");
        Mode = 1'b1;
        load_b(8'hFF);
        mult(8'hFF, 8'h00, 8'h01, 1'b0, "signed_ff");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
